tag_phase_stage: RTL and testbench
==================================

Name: tag_phase_stage

Overview:
- First phase of the phased cache lookup: 8-way tag store with valid bits, per-set round-robin pointer, tag compare.
- Produces a registered one-hot-or-multi-hot way-hit vector and a victim candidate vector, one cycle after request.
- Feeds the downstream 8-to-3 priority encoder (way index), which drives the data-array phase.
- Accepts fills from the refill path and a whole-cache invalidate (flush).

Parameters:
- WAYS, 8, number of ways; fixed at 8 to match the 8-to-3 encoder.
- SET_BITS, 4, log2 of number of sets (16 sets).
- TAG_BITS, 20, tag width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  stage can accept a lookup this cycle.
- req_set  in  SET_BITS  lookup set index.
- req_tag  in  TAG_BITS  lookup tag.
- fill_valid  in  1  write tag into way (single-cycle pulse per fill).
- fill_set  in  SET_BITS  fill set index.
- fill_way  in  3  fill way index.
- fill_tag  in  TAG_BITS  fill tag.
- flush_req  in  1  start whole-cache invalidate (pulse).
- flush_done  out  1  one-cycle pulse when flush completes.
- out_valid  out  1  result register valid.
- out_ready  in  1  downstream (encoder/data phase) consumes result.
- out_hit  out  1  OR of out_hit_vec.
- out_hit_vec  out  8  bit w = valid[set][w] and tag[set][w]==req_tag.
- out_victim_vec  out  8  replacement candidate vector for the encoder.
- out_set  out  SET_BITS  registered req_set.
- out_tag  out  TAG_BITS  registered req_tag.

Behaviour:
- Reset (sync, active-high): all valid bits 0, all rr pointers 0, state IDLE, out_valid 0, out_hit 0, out_hit_vec 0, out_victim_vec 0, out_set 0, out_tag 0, flush_done 0, req_ready 0 during the reset cycle. Tag storage not reset. Reset mid-flush or with out_valid=1 aborts/discards; no flush_done.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH on flush_req; flush counter loads 0.
  - FLUSH: clears valid bits of set[counter] each cycle; counter+1; after set 2^SET_BITS-1 -> IDLE with flush_done=1 that same edge (flush takes exactly 2^SET_BITS cycles).
  - flush_req in FLUSH is ignored.
- req_ready = (state==IDLE) and !fill_valid and !flush_req and (!out_valid or out_ready).
- Accept = req_valid and req_ready. Latency 1: on accept, out_* load the compare result next edge, out_valid=1.
- out_valid clears when out_ready=1 and there is no new accept. The output is held stable while out_valid=1 and out_ready=0.
- Compare uses the state before the current edge. A fill never coincides with an accept (fill priority via req_ready).
- Multiple matching ways: all bits set; no error. Downstream encoder picks the highest index.
- Victim vector:
  - If any way in the set is invalid: vector = ~valid[set] (encoder picks the highest invalid way).
  - Otherwise: one-hot(rr[set]).
- Fill: tag[fill_set][fill_way] <= fill_tag, valid <= 1. If fill_way == rr[fill_set], rr[fill_set] <= rr+1 mod 8 (wraps 7->0).
- fill_valid during FLUSH: ignored (dropped); the refill path must not fill during flush.
- flush_req with out_valid=1: the held result remains until consumed; the flush proceeds regardless.

Decomposition:
- Shared package (cache_pkg): WAYS, SET_BITS, TAG_BITS constants; state enum {IDLE, FLUSH}; way index type (3 bits).
- One natural sub-module: tag_way_compare (single way: valid, stored tag, lookup tag -> match bit), instantiated 8 times.
- Tag/valid/rr arrays stay in the parent.

Test Plan:
- Reset then lookup set 3, tag 0x12345 -> next cycle out_valid=1, out_hit=0, out_hit_vec=0x00, out_victim_vec=0xFF.
- Fill set 3 way 5 tag 0x12345, then lookup set 3 tag 0x12345 -> out_hit_vec=0x20, out_hit=1, out_victim_vec=0xDF.
- Fill all 8 ways of set 7 in order 0..7 -> rr[7] wraps to 0; miss lookup gives out_victim_vec=0x01. Fill way 0 -> rr=1; next miss gives 0x02.
- out_ready=0 with out_valid=1, req_valid=1 -> req_ready=0; out_* unchanged for 5 cycles. Raise out_ready -> new request accepted, result in the following cycle.
- fill_valid and req_valid in the same cycle -> req_ready=0, fill applied; the request, accepted next cycle, sees the filled tag as a hit.
- flush_req after populating sets 0..15 -> req_ready=0 for 16 cycles, flush_done pulses once, all lookups miss with victim 0xFF. Reset at flush cycle 8 -> no flush_done, all valid bits 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and types for the phased cache lookup (tag phase).
package cache_pkg;

    localparam int WAYS     = 8;
    localparam int WAY_BITS = 3;
    localparam int SET_BITS = 4;
    localparam int TAG_BITS = 20;
    localparam int SETS     = 1 << SET_BITS;

    // Control state of the tag stage: normal lookups or whole-cache invalidate.
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef logic [WAY_BITS-1:0] way_idx_t;

    // One-hot vector selecting a single way.
    function automatic logic [WAYS-1:0] way_onehot(input way_idx_t w);
        return WAYS'(1) << w;
    endfunction

endpackage

// File: rtl/tag_way_compare.sv
// Single-way tag comparator: a way hits when it holds a valid line whose
// stored tag equals the lookup tag.
module tag_way_compare
    import cache_pkg::*;
(
    input  logic                i_valid,
    input  logic [TAG_BITS-1:0] i_stored_tag,
    input  logic [TAG_BITS-1:0] i_lookup_tag,
    output logic                o_match
);

    // Pure combinational match; the parent registers the result.
    assign o_match = i_valid && (i_stored_tag == i_lookup_tag);

endmodule

// File: rtl/tag_phase_stage.sv
// Tag phase of the phased cache lookup: 8-way tag store with valid bits and a
// per-set round-robin pointer. A lookup produces a registered way-hit vector
// and a victim candidate vector one cycle after it is accepted. Also handles
// refills and a whole-cache invalidate that walks one set per cycle.
module tag_phase_stage
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SET_BITS-1:0] req_set,
    input  logic [TAG_BITS-1:0] req_tag,

    input  logic                fill_valid,
    input  logic [SET_BITS-1:0] fill_set,
    input  logic [2:0]          fill_way,
    input  logic [TAG_BITS-1:0] fill_tag,

    input  logic                flush_req,
    output logic                flush_done,

    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_hit,
    output logic [WAYS-1:0]     out_hit_vec,
    output logic [WAYS-1:0]     out_victim_vec,
    output logic [SET_BITS-1:0] out_set,
    output logic [TAG_BITS-1:0] out_tag
);

    // ------------------------------------------------------------------
    // Storage. Tags are never reset: a line is only meaningful while its
    // valid bit is set, and valid bits are always cleared on reset.
    // ------------------------------------------------------------------
    logic [TAG_BITS-1:0] r_tag_mem [SETS][WAYS];
    logic [WAYS-1:0]     r_valid   [SETS];
    way_idx_t            r_rr      [SETS];

    state_t              r_state;
    logic [SET_BITS-1:0] r_flush_cnt;
    logic                r_flush_done;

    logic                r_out_valid;
    logic                r_out_hit;
    logic [WAYS-1:0]     r_out_hit_vec;
    logic [WAYS-1:0]     r_out_victim_vec;
    logic [SET_BITS-1:0] r_out_set;
    logic [TAG_BITS-1:0] r_out_tag;

    // ------------------------------------------------------------------
    // Handshake. Fills and flush requests take priority over lookups by
    // withholding req_ready, so a fill never lands on the same edge as an
    // accepted lookup. A held (unconsumed) result also blocks new lookups.
    // ------------------------------------------------------------------
    logic w_req_ready;
    logic w_accept;
    logic w_fill_en;
    logic w_flush_last;

    assign w_req_ready = !reset
                      && (r_state == IDLE)
                      && !fill_valid
                      && !flush_req
                      && (!r_out_valid || out_ready);
    assign w_accept    = req_valid && w_req_ready;

    // Fills arriving while the invalidate is walking the sets are dropped.
    assign w_fill_en   = fill_valid && (r_state == IDLE);

    assign w_flush_last = (r_flush_cnt == SET_BITS'(SETS - 1));

    // ------------------------------------------------------------------
    // Tag compare for the requested set, one comparator per way. The
    // compare always sees the arrays as they were before the current edge.
    // ------------------------------------------------------------------
    logic [WAYS-1:0]     w_set_valid;
    logic [TAG_BITS-1:0] w_set_tag [WAYS];
    logic [WAYS-1:0]     w_hit_vec;
    logic [WAYS-1:0]     w_victim_vec;

    assign w_set_valid = r_valid[req_set];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign w_set_tag[gi] = r_tag_mem[req_set][gi];

            tag_way_compare u_cmp (
                .i_valid      (w_set_valid[gi]),
                .i_stored_tag (w_set_tag[gi]),
                .i_lookup_tag (req_tag),
                .o_match      (w_hit_vec[gi])
            );
        end
    endgenerate

    // Prefer filling an empty way; once the set is full fall back to the
    // round-robin pointer. The encoder takes the highest set bit, so with
    // several invalid ways the highest-numbered one is chosen.
    assign w_victim_vec = (&w_set_valid) ? way_onehot(r_rr[req_set])
                                         : ~w_set_valid;

    // ------------------------------------------------------------------
    // Tag write on refill (no reset on the tag array).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_fill_en) begin
            r_tag_mem[fill_set][fill_way] <= fill_tag;
        end
    end

    // ------------------------------------------------------------------
    // Valid bits and round-robin pointers: cleared on reset, cleared one
    // set per cycle during an invalidate, set/advanced by refills.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (r_state == FLUSH) begin
            r_valid[r_flush_cnt] <= '0;
        end else if (w_fill_en) begin
            r_valid[fill_set][fill_way] <= 1'b1;
            // Only advance when the pointed-at way was just refilled, so the
            // pointer tracks the oldest replacement slot.
            if (fill_way == r_rr[fill_set]) begin
                r_rr[fill_set] <= r_rr[fill_set] + way_idx_t'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Invalidate FSM: walks every set once, pulsing flush_done on the edge
    // that returns to IDLE. A flush request during a flush is ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_flush_cnt  <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (flush_req) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + SET_BITS'(1);
                    if (w_flush_last) begin
                        r_state      <= IDLE;
                        r_flush_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result register: loads on accept, drops valid once consumed with no
    // replacement, and holds all fields while stalled by the consumer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_out_hit        <= 1'b0;
            r_out_hit_vec    <= '0;
            r_out_victim_vec <= '0;
            r_out_set        <= '0;
            r_out_tag        <= '0;
        end else if (w_accept) begin
            r_out_valid      <= 1'b1;
            r_out_hit        <= |w_hit_vec;
            r_out_hit_vec    <= w_hit_vec;
            r_out_victim_vec <= w_victim_vec;
            r_out_set        <= req_set;
            r_out_tag        <= req_tag;
        end else if (out_ready) begin
            r_out_valid      <= 1'b0;
        end
    end

    assign req_ready      = w_req_ready;
    assign flush_done     = r_flush_done;
    assign out_valid      = r_out_valid;
    assign out_hit        = r_out_hit;
    assign out_hit_vec    = r_out_hit_vec;
    assign out_victim_vec = r_out_victim_vec;
    assign out_set        = r_out_set;
    assign out_tag        = r_out_tag;

endmodule

// File: tb/tb_tag_phase_stage.sv
// Testbench for tag_phase_stage: directed scenarios followed by random
// traffic, every cycle checked against a behavioural cache model.
module tb_tag_phase_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_set;
    logic [19:0] req_tag;
    logic        fill_valid;
    logic [3:0]  fill_set;
    logic [2:0]  fill_way;
    logic [19:0] fill_tag;
    logic        flush_req;
    logic        flush_done;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic [7:0]  out_hit_vec;
    logic [7:0]  out_victim_vec;
    logic [3:0]  out_set;
    logic [19:0] out_tag;

    int errors = 0;
    int checks = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    tag_phase_stage dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_set        (req_set),
        .req_tag        (req_tag),
        .fill_valid     (fill_valid),
        .fill_set       (fill_set),
        .fill_way       (fill_way),
        .fill_tag       (fill_tag),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_hit        (out_hit),
        .out_hit_vec    (out_hit_vec),
        .out_victim_vec (out_victim_vec),
        .out_set        (out_set),
        .out_tag        (out_tag)
    );

    // ---------------- behavioural model of the cache tag state ----------
    bit          m_valid [16][8];
    logic [19:0] m_tag   [16][8];
    int          m_rr    [16];
    int          m_flush_left = 0;   // sets still to be invalidated
    bit          m_flush_done = 0;
    bit          m_out_valid = 0;
    logic [7:0]  m_hit_vec = 0;
    logic [7:0]  m_victim = 0;
    logic [3:0]  m_set = 0;
    logic [19:0] m_otag = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=0x%0h expected=0x%0h", name, $time, obs, exp);
        end
    endtask

    // One clock cycle: check req_ready, advance the model, check outputs.
    task automatic tick();
        bit         exp_ready, acc;
        logic [7:0] hv, vv, sv;
        @(negedge clk);
        exp_ready = !reset && (m_flush_left == 0) && !fill_valid && !flush_req
                    && (!m_out_valid || out_ready);
        check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        acc = req_valid && exp_ready;
        for (int w = 0; w < 8; w++) begin
            sv[w] = m_valid[req_set][w];
            hv[w] = m_valid[req_set][w] && (m_tag[req_set][w] == req_tag);
        end
        vv = (sv == 8'hFF) ? 8'(1 << m_rr[req_set]) : ~sv;
        @(posedge clk);
        if (reset) begin
            for (int s = 0; s < 16; s++) begin
                m_rr[s] = 0;
                for (int w = 0; w < 8; w++) m_valid[s][w] = 0;
            end
            m_flush_left = 0; m_flush_done = 0; m_out_valid = 0;
            m_hit_vec = 0; m_victim = 0; m_set = 0; m_otag = 0;
        end else begin
            m_flush_done = 0;
            if (m_flush_left > 0) begin
                for (int w = 0; w < 8; w++) m_valid[16 - m_flush_left][w] = 0;
                m_flush_left--;
                if (m_flush_left == 0) m_flush_done = 1;
            end else begin
                if (fill_valid) begin
                    m_tag[fill_set][fill_way] = fill_tag;
                    m_valid[fill_set][fill_way] = 1;
                    if (int'(fill_way) == m_rr[fill_set]) m_rr[fill_set] = (m_rr[fill_set] + 1) % 8;
                end
                if (flush_req) m_flush_left = 16;
            end
            if (acc) begin
                m_out_valid = 1; m_hit_vec = hv; m_victim = vv; m_set = req_set; m_otag = req_tag;
            end else if (out_ready) begin
                m_out_valid = 0;
            end
        end
        #1;
        if (flush_done) done_count++;
        check("out_valid",  {31'd0, out_valid},      {31'd0, m_out_valid});
        check("out_hit_vec", {24'd0, out_hit_vec},   {24'd0, m_hit_vec});
        check("out_hit",    {31'd0, out_hit},        {31'd0, |m_hit_vec});
        check("out_victim", {24'd0, out_victim_vec}, {24'd0, m_victim});
        check("out_set",    {28'd0, out_set},        {28'd0, m_set});
        check("out_tag",    {12'd0, out_tag},        {12'd0, m_otag});
        check("flush_done", {31'd0, flush_done},     {31'd0, m_flush_done});
    endtask

    task automatic quiet();
        reset = 0; req_valid = 0; fill_valid = 0; flush_req = 0; out_ready = 1;
    endtask

    task automatic lookup(input logic [3:0] s, input logic [19:0] t);
        quiet(); req_valid = 1; req_set = s; req_tag = t;
        tick();
        req_valid = 0;
    endtask

    task automatic fill(input logic [3:0] s, input logic [2:0] w, input logic [19:0] t);
        quiet(); fill_valid = 1; fill_set = s; fill_way = w; fill_tag = t;
        tick();
        fill_valid = 0;
    endtask

    initial begin
        int d0;
        quiet();
        req_set = 0; req_tag = 0; fill_set = 0; fill_way = 0; fill_tag = 0;

        // Reset for two cycles.
        reset = 1; tick(); tick(); reset = 0;

        // Empty cache: miss, every way a victim candidate.
        lookup(4'd3, 20'h12345);
        check("tp_empty_hitvec", {24'd0, out_hit_vec}, 32'h00);
        check("tp_empty_victim", {24'd0, out_victim_vec}, 32'hFF);

        // Single line fill then hit.
        fill(4'd3, 3'd5, 20'h12345);
        lookup(4'd3, 20'h12345);
        check("tp_fill_hitvec", {24'd0, out_hit_vec}, 32'h20);
        check("tp_fill_victim", {24'd0, out_victim_vec}, 32'hDF);

        // Fill every way of set 7: pointer wraps, victim is way 0, then way 1.
        for (int w = 0; w < 8; w++) fill(4'd7, 3'(w), 20'h700 + 20'(w));
        lookup(4'd7, 20'hABCDE);
        check("tp_rr_wrap", {24'd0, out_victim_vec}, 32'h01);
        fill(4'd7, 3'd0, 20'h77777);
        lookup(4'd7, 20'hABCDE);
        check("tp_rr_next", {24'd0, out_victim_vec}, 32'h02);

        // Back-pressure: result held for 5 cycles while out_ready=0.
        lookup(4'd7, 20'h701);
        out_ready = 0; req_valid = 1; req_set = 4'd3; req_tag = 20'h12345;
        for (int i = 0; i < 5; i++) tick();
        check("tp_hold_vec", {24'd0, out_hit_vec}, 32'h02);
        out_ready = 1; tick();
        req_valid = 0; tick();
        check("tp_release_vec", {24'd0, out_hit_vec}, 32'h20);

        // Fill and request in the same cycle: fill wins, request then hits.
        quiet(); fill_valid = 1; fill_set = 4'd9; fill_way = 3'd2; fill_tag = 20'h55555;
        req_valid = 1; req_set = 4'd9; req_tag = 20'h55555;
        tick();
        fill_valid = 0; tick();
        check("tp_fill_then_hit", {24'd0, out_hit_vec}, 32'h04);
        req_valid = 0; tick();

        // Populate every set, then flush with a request held high throughout.
        for (int s = 0; s < 16; s++) fill(4'(s), 3'(s % 8), 20'(s));
        d0 = done_count;
        quiet(); flush_req = 1; req_valid = 1; req_set = 4'd4; req_tag = 20'd4;
        tick();
        flush_req = 0;
        for (int i = 0; i < 16; i++) tick();
        req_valid = 0; tick();
        check("tp_flush_done_once", 32'(done_count - d0), 32'd1);
        for (int s = 0; s < 16; s++) begin
            lookup(4'(s), 20'(s));
            check("tp_post_flush_victim", {24'd0, out_victim_vec}, 32'hFF);
        end

        // Reset in the middle of a flush: no completion pulse, cache empty.
        for (int s = 0; s < 16; s++) fill(4'(s), 3'd1, 20'(s));
        d0 = done_count;
        quiet(); flush_req = 1; tick(); flush_req = 0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 20; i++) tick();
        check("tp_reset_flush_nodone", 32'(done_count - d0), 32'd0);
        for (int s = 0; s < 16; s++) begin
            lookup(4'(s), 20'(s));
            check("tp_post_reset_hit", {31'd0, out_hit}, 32'd0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 599) == 0);
            flush_req  = ($urandom_range(0, 149) == 0);
            req_valid  = ($urandom_range(0, 99) < 70);
            out_ready  = ($urandom_range(0, 99) < 70);
            fill_valid = ($urandom_range(0, 99) < 30);
            req_set    = 4'($urandom_range(0, 3));
            req_tag    = 20'($urandom_range(0, 5));
            fill_set   = 4'($urandom_range(0, 3));
            fill_way   = 3'($urandom_range(0, 7));
            fill_tag   = 20'($urandom_range(0, 5));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
